// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared FSM/classifier types, keypad geometry and frame classifier
package key_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_SINGLE,
        KIND_MULTI
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [3:0] code;
    } class_t;

    // Frame bit index is col*NUM_ROWS + row; the reported code is row*NUM_COLS + col.
    function automatic class_t key_classify(input logic [NUM_KEYS-1:0] frame);
        class_t      res;
        int unsigned hits;
        res.kind = KIND_NONE;
        res.code = '0;
        hits     = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (frame[i]) begin
                hits     = hits + 1;
                res.code = 4'((i % NUM_ROWS) * NUM_COLS + (i / NUM_ROWS));
            end
        end
        if (hits == 1) begin
            res.kind = KIND_SINGLE;
        end else if (hits > 1) begin
            res.kind = KIND_MULTI;
        end
        return res;
    endfunction

endpackage

// File: rtl/key_scan_timer.sv
// rtl/key_scan_timer.sv - column-slot prescaler and column counter for key_scan_4x4
module key_scan_timer
    import key_pkg::*;
#(
    parameter int SCAN_DIV = 12500
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tick,
    output logic [1:0] col,
    output logic       frame_end
);

    localparam int            PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;

    assign tick      = (presc == LAST);
    assign frame_end = tick && (col == 2'(NUM_COLS - 1));

    // Prescaler: one tick per column slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Column counter: advances on tick; the 2-bit width gives the 3->0 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= 2'd0;
        end else if (tick) begin
            col <= col + 2'd1;
        end
    end

endmodule

// File: rtl/key_scan_4x4.sv
// rtl/key_scan_4x4.sv - 4x4 keypad scanner with per-frame debounce; auto-repeat under KEY_SCAN_REPEAT_EN
module key_scan_4x4
    import key_pkg::*;
#(
    parameter int SCAN_DIV        = 12500,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_DELAY    = 40,
    parameter int REPEAT_RATE     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_FRAMES);

    if (SCAN_DIV < 4) begin : g_chk_div
        $error("key_scan_4x4: SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_chk_deb
        $error("key_scan_4x4: DEBOUNCE_FRAMES must be 1..15");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_chk_rep
        $error("key_scan_4x4: REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    logic                tick;
    logic                frame_end;
    logic [1:0]          col;
    logic [3:0]          row_meta;
    logic [3:0]          row_sync;
    logic [NUM_KEYS-1:0] frame;
    logic [NUM_KEYS-1:0] frame_next;
    class_t              cls;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [3:0] cand, cand_next;
    logic [3:0] code_next;
    logic       valid_next;

    key_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .col       (col),
        .frame_end (frame_end)
    );

    assign key_col  = ~(4'b0001 << col);
    assign key_down = (state == PRESSED) || (state == RELEASE);

    // Two-flop synchronizer for the asynchronous row lines (idle level is all-high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
        end
    end

    // Frame image including the slot being sampled this tick; classified at frame end.
    always_comb begin
        frame_next                        = frame;
        frame_next[{col, 2'b00} +: NUM_ROWS] = ~row_sync;
    end

    assign cls = key_classify(frame_next);

    // Frame register: collects one column of pressed rows per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame <= '0;
        end else if (tick) begin
            frame <= frame_next;
        end
    end

`ifdef KEY_SCAN_REPEAT_EN
    logic [15:0] rep_cnt, rep_cnt_next;
    logic        rep_first, rep_first_next;

    // Repeat counter: held frames since acceptance or since the last repeat pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt_next;
            rep_first <= rep_first_next;
        end
    end
`endif

    // Debounce FSM state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cand      <= cand_next;
            key_code  <= code_next;
            key_valid <= valid_next;
        end
    end

    // Debounce FSM next-state logic; only frame-end ticks move it.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        code_next  = key_code;
        valid_next = 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
        rep_cnt_next   = rep_cnt;
        rep_first_next = rep_first;
`endif
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (cls.kind == KIND_SINGLE) begin
                        cand_next = cls.code;
                        cnt_next  = 4'd1;
                        if (DEB_LAST == 4'd1) begin
                            code_next  = cls.code;
                            valid_next = 1'b1;
                            state_next = PRESSED;
`ifdef KEY_SCAN_REPEAT_EN
                            rep_cnt_next   = '0;
                            rep_first_next = 1'b1;
`endif
                        end else begin
                            state_next = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (cls.kind != KIND_SINGLE) begin
                        state_next = IDLE;
                    end else if (cls.code != cand) begin
                        cand_next = cls.code;
                        cnt_next  = 4'd1;
                    end else begin
                        cnt_next = cnt + 4'd1;
                        if (cnt + 4'd1 == DEB_LAST) begin
                            code_next  = cand;
                            valid_next = 1'b1;
                            state_next = PRESSED;
`ifdef KEY_SCAN_REPEAT_EN
                            rep_cnt_next   = '0;
                            rep_first_next = 1'b1;
`endif
                        end
                    end
                end
                PRESSED: begin
                    if (cls.kind == KIND_NONE) begin
                        cnt_next   = 4'd1;
                        state_next = (DEB_LAST == 4'd1) ? IDLE : RELEASE;
                    end else begin
`ifdef KEY_SCAN_REPEAT_EN
                        rep_cnt_next = rep_cnt + 16'd1;
                        if (rep_cnt + 16'd1 == (rep_first ? 16'(REPEAT_DELAY) : 16'(REPEAT_RATE))) begin
                            valid_next     = 1'b1;
                            rep_cnt_next   = '0;
                            rep_first_next = 1'b0;
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (cls.kind == KIND_NONE) begin
                        cnt_next = cnt + 4'd1;
                        if (cnt + 4'd1 == DEB_LAST) begin
                            state_next = IDLE;
                        end
                    end else begin
                        state_next = PRESSED;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_scan_4x4.sv
// tb/tb_key_scan_4x4.sv - self-checking bench for key_scan_4x4 (repeat checks under KEY_SCAN_REPEAT_EN)
module tb_key_scan_4x4;

    localparam int DEB = 3;
    localparam int RD  = 4;
    localparam int RR  = 2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;

    key_scan_4x4 #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: pressed bit (r*4+c) shorts row r to column c.
    always_comb begin
        key_row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!key_col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[r*4+c]) key_row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: run lengths of identical single-key frames and of empty frames.
    int         m_held, m_srun, m_nrun, m_rep, m_rep_first;
    logic [15:0] m_last;
    logic [3:0]  m_code;

    task automatic model_reset();
        m_held = 0; m_srun = 0; m_nrun = 0; m_rep = 0; m_rep_first = 1;
        m_last = '0; m_code = 4'd0;
    endtask

    task automatic model_step(input logic [15:0] mask, output int v, output logic [3:0] code, output logic down);
        int n;
        n = $countones(mask);
        v = 0;
        if (m_held == 0) begin
            if (n == 1) begin
                if (m_srun > 0 && mask == m_last) m_srun++;
                else m_srun = 1;
                m_last = mask;
                if (m_srun >= DEB) begin
                    m_held = 1; m_nrun = 0; v = 1; m_rep = 0; m_rep_first = 1;
                    for (int i = 0; i < 16; i++) if (mask[i]) m_code = 4'(i);
                end
            end else begin
                m_srun = 0;
            end
        end else if (n == 0) begin
            m_nrun++;
            if (m_nrun >= DEB) begin m_held = 0; m_srun = 0; m_nrun = 0; end
        end else begin
`ifdef KEY_SCAN_REPEAT_EN
            if (m_nrun == 0) begin
                m_rep++;
                if (m_rep == (m_rep_first != 0 ? RD : RR)) begin v = 1; m_rep = 0; m_rep_first = 0; end
            end
`endif
            m_nrun = 0;
        end
        code = m_code;
        down = (m_held != 0);
    endtask

    // One 16-cycle frame with a stable key mask; must start right after a negedge at frame start.
    task automatic do_frame(input logic [15:0] mask, input bit use_model, input int ev, input logic [3:0] ecode,
                            input logic edown, input string tag);
        int         pulses, early, col_err, mv;
        logic [3:0] mcode, exp_col;
        logic       mdown;
        model_step(mask, mv, mcode, mdown);
        if (use_model) begin ev = mv; ecode = mcode; edown = mdown; end
        pressed = mask; pulses = 0; early = 0; col_err = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); @(negedge clk);
            exp_col = ~(4'b0001 << (((i + 1) / 4) % 4));
            if (key_col !== exp_col) col_err++;
            if (key_valid === 1'b1) begin pulses++; if (i != 15) early++; end
        end
        check({tag, " valid_pulses"}, pulses + 16 * early, ev);
        check({tag, " key_down"}, {31'd0, key_down}, {31'd0, edown});
        check({tag, " key_code"}, {28'd0, key_code}, {28'd0, ecode});
        check({tag, " key_col_seq"}, col_err, 0);
    endtask

    typedef struct {
        logic [15:0] mask;
        int          v;
        logic [3:0]  code;
        logic        down;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [15:0] mask, input int v, input logic [3:0] code, input logic down);
        vec_t e;
        e.mask = mask; e.v = v; e.code = code; e.down = down;
        tbl.push_back(e);
    endfunction

    initial begin
        logic [15:0] prev, mask;
        int          r;

        rst_n = 1'b0;
        pressed = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset key_col", {28'd0, key_col}, 32'hE);
        check("reset key_valid", {31'd0, key_valid}, 0);
        check("reset key_down", {31'd0, key_down}, 0);
        check("reset key_code", {28'd0, key_code}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) add(16'h0000, 0, 4'd0, 1'b0);
        add(16'h0200, 0, 4'd0, 1'b0); add(16'h0200, 0, 4'd0, 1'b0);
        add(16'h0200, 1, 4'd9, 1'b1); add(16'h0200, 0, 4'd9, 1'b1);
        add(16'h0000, 0, 4'd9, 1'b1); add(16'h0200, 0, 4'd9, 1'b1);
        add(16'h0000, 0, 4'd9, 1'b1); add(16'h0000, 0, 4'd9, 1'b1);
        add(16'h0000, 0, 4'd9, 1'b0);
        for (int i = 0; i < 10; i++) add(16'h0021, 0, 4'd9, 1'b0);
        add(16'h0010, 0, 4'd9, 1'b0); add(16'h0010, 0, 4'd9, 1'b0); add(16'h0000, 0, 4'd9, 1'b0);
        add(16'h0008, 0, 4'd9, 1'b0); add(16'h0008, 0, 4'd9, 1'b0);
        add(16'h0080, 0, 4'd9, 1'b0); add(16'h0080, 0, 4'd9, 1'b0); add(16'h0080, 1, 4'd7, 1'b1);
        add(16'h2080, 0, 4'd7, 1'b1); add(16'h2000, 0, 4'd7, 1'b1);
        add(16'h0000, 0, 4'd7, 1'b1); add(16'h0000, 0, 4'd7, 1'b1); add(16'h0000, 0, 4'd7, 1'b0);

        foreach (tbl[i]) do_frame(tbl[i].mask, 1'b0, tbl[i].v, tbl[i].code, tbl[i].down, $sformatf("tbl[%0d]", i));

`ifdef KEY_SCAN_REPEAT_EN
        for (int f = 1; f <= 12; f++) begin
            do_frame(16'h8000, 1'b0, (f == 3 || f == 7 || f == 9 || f == 11) ? 1 : 0,
                     (f >= 3) ? 4'd15 : 4'd7, (f >= 3), $sformatf("repeat f%0d", f));
        end
        do_frame(16'h0000, 1'b0, 0, 4'd15, 1'b1, "repeat rel1");
        do_frame(16'h0000, 1'b0, 0, 4'd15, 1'b1, "repeat rel2");
        do_frame(16'h0000, 1'b0, 0, 4'd15, 1'b0, "repeat rel3");
`endif

        prev = '0;
        for (int f = 0; f < 120; f++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      mask = prev;
            else if (r < 6) mask = '0;
            else if (r < 9) mask = 16'(1) << $urandom_range(0, 15);
            else            mask = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            do_frame(mask, 1'b1, 0, 4'd0, 1'b0, $sformatf("rand[%0d]", f));
            prev = mask;
        end

        for (int f = 0; f < 3; f++) do_frame(16'h0000, 1'b1, 0, 4'd0, 1'b0, $sformatf("drain[%0d]", f));
        for (int f = 0; f < 5; f++) do_frame(16'h8000, 1'b1, 0, 4'd0, 1'b0, $sformatf("hold15[%0d]", f));

        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset key_col", {28'd0, key_col}, 32'hE);
        check("midreset key_valid", {31'd0, key_valid}, 0);
        check("midreset key_down", {31'd0, key_down}, 0);
        check("midreset key_code", {28'd0, key_code}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_frame(16'h8000, 1'b0, 0, 4'd0, 1'b0, "post_reset f1");
        do_frame(16'h8000, 1'b0, 0, 4'd0, 1'b0, "post_reset f2");
        do_frame(16'h8000, 1'b0, 1, 4'd15, 1'b1, "post_reset f3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_scan_4x4.md
# key_scan_4x4

Scans a 4x4 matrix keypad. It drives one active-low column at a time and samples four active-low rows. It debounces per frame and reports each accepted press as a one-cycle strobe plus a 4-bit key code. It is the input-side counterpart of the display scan driver: it sits beside it on the same board clock and feeds key codes to the application logic that chooses digit data.

## Interface
Parameters:
- SCAN_DIV, default 12500: clk cycles per column slot; legal range is 4 or more.
- DEBOUNCE_FRAMES, default 3: consecutive identical full frames needed to accept a press or a release; legal range is 1–15.
- REPEAT_DELAY, default 40: held frames before the first auto-repeat. Used only when KEY_SCAN_REPEAT_EN is defined.
- REPEAT_RATE, default 10: held frames between subsequent repeats. Used only when KEY_SCAN_REPEAT_EN is defined.

Ports:
- clk  in  1  system clock (50 MHz board clock)
- rst_n  in  1  asynchronous, active-low reset
- key_row  in  4  row lines, active-low; external pull-ups, asynchronous to clk
- key_col  out  4  column drive, active-low, exactly one bit low
- key_code  out  4  code of the last accepted key = row*4 + col
- key_valid  out  1  one-cycle strobe; key_code is valid in the same cycle
- key_down  out  1  level, high while the accepted key is held

## Operation
- Row synchronizer:
  - key_row passes through a 2-flop synchronizer, reset to 4'hF.
  - The FSM sees only the synchronized value.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - `tick` is asserted when the count equals SCAN_DIV-1.
- Column counter col (0..3):
  - Advances on tick and wraps 3→0.
  - key_col = ~(4'b0001 << col).
- Sampling:
  - On tick, the synchronized rows are inverted and stored into frame bits [col*4 +: 4], before col advances.
  - The tick with col==3 ends a frame and produces the 16-bit snapshot `frame`.
- Frame classification:
  - NONE when no bits are set.
  - SINGLE(k) when exactly one bit is set; k = row*4+col.
  - MULTI otherwise.
- Debounce FSM, evaluated only at frame end:
  - IDLE:
    - SINGLE(k): cand←k, cnt←1, go to DEBOUNCE.
    - NONE or MULTI: stay in IDLE.
  - DEBOUNCE:
    - SINGLE(cand): cnt+1.
    - When cnt reaches DEBOUNCE_FRAMES: key_code←cand, pulse key_valid, go to PRESSED.
    - SINGLE(other k): restart with cand←k, cnt←1.
    - NONE or MULTI: go to IDLE.
  - PRESSED:
    - Any frame that is not NONE (including MULTI or a different key): stay; the key is still held.
    - NONE: cnt←1, go to RELEASE.
  - RELEASE:
    - NONE: cnt+1; at DEBOUNCE_FRAMES go to IDLE.
    - Any other frame: go back to PRESSED. No new key_valid is issued.
- A second key pressed while one is held is never reported until a full release.
- key_down is high in PRESSED and RELEASE.
- If DEBOUNCE_FRAMES=1, the first SINGLE frame goes directly to PRESSED.

## Timing
- Reset values (asynchronous, all at once):
  - Prescaler=0, col=0, key_col=4'b1110.
  - key_code=0, key_valid=0, key_down=0.
  - FSM=IDLE, cnt=0, frame=0.
- Frame length: 4*SCAN_DIV cycles.
- key_valid rises in the clk cycle after the frame-end tick that completes debounce.
  - It is high for exactly 1 cycle.
  - key_down rises in the same cycle.
- key_down falls in the cycle after the frame-end tick that completes the release count.
- Input latency: 2 cycles of synchronizer. SCAN_DIV≥4 guarantees rows have settled after a column change.
- If reset is asserted mid-frame, the partial frame is discarded and the first frame after reset starts at col=0.

## Configuration
- KEY_SCAN_REPEAT_EN defined:
  - PRESSED counts held frames in rep_cnt.
  - After REPEAT_DELAY frames, key_valid pulses again with the same key_code.
  - After that, it pulses every REPEAT_RATE frames.
  - rep_cnt resets on entry to PRESSED from DEBOUNCE.
  - rep_cnt is held, not reset, across a RELEASE→PRESSED bounce.
- Not defined:
  - Exactly one key_valid per accepted press.
  - REPEAT_* parameters are unused and rep_cnt is not built.

## Structure
- Shared package key_pkg holds:
  - FSM state enum: IDLE, DEBOUNCE, PRESSED, RELEASE.
  - Constants NUM_ROWS=4 and NUM_COLS=4.
  - Function key_classify(frame), returning {kind, code}.
- Sub-module key_scan_timer: the prescaler plus column counter. Outputs tick, col and frame_end.
- The top level holds the synchronizer, frame register and FSM.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_FRAMES=3, so one frame is 16 cycles.
- Reset, then all rows high for 10 frames → key_col cycles 1110,1101,1011,0111 every 4 cycles; key_valid is never asserted; key_down=0.
- Row 2 pulled low only while col=1 is driven, held steady → exactly one key_valid at the end of the 3rd complete frame with key_code=9; key_down=1.
- Hold code 9, then release and bounce with the pattern NONE, SINGLE(9), NONE, NONE, NONE → key_down stays 1 through the bounce and falls after the 3rd consecutive NONE frame; no extra key_valid.
- Press codes 0 and 5 simultaneously (MULTI) for 10 frames → no key_valid; FSM stays in IDLE.
- Frames SINGLE(3), SINGLE(3), SINGLE(7), SINGLE(7), SINGLE(7) → a single key_valid with key_code=7.
- With KEY_SCAN_REPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2, code 15 held for 12 frames → key_valid at acceptance, then after 4 more frames, then every 2 frames, each time with key_code=15. Assert rst_n low mid-hold → all outputs return to their reset values immediately.
